// File: rtl/stand_cell_bank.sv
// stand_cell_bank: multi-channel inertial inverter/buffer with asymmetric
// propagation delays counted in U cycles. Pulses shorter than the pending
// delay are swallowed, so _Q never glitches.
// Optional BUSY output (per-channel transition pending): define STANDCELL_BUSY_EN.

module stand_cell_lane #(
  parameter int TPHL   = 7,
  parameter int TPLH   = 31,
  parameter int INVERT = 1,
  parameter int CW     = 5
) (
  input  logic U,
  input  logic RESET,
  input  logic d_i,
  output logic q_o
);
  localparam logic          RST_Q = (INVERT != 0);
  localparam logic [CW-1:0] HL_M1 = CW'(TPHL - 1);
  localparam logic [CW-1:0] LH_M1 = CW'(TPLH - 1);

  logic          tgt;
  logic [CW-1:0] lim_m1;
  logic          q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Settled channels hold a cleared counter; pending ones count toward the
  // delay of the direction they are heading, then commit.
  always_comb begin
    tgt    = (INVERT != 0) ? ~d_i : d_i;
    lim_m1 = tgt ? LH_M1 : HL_M1;
    q_d    = q_q;
    cnt_d  = '0;
    if (tgt != q_q) begin
      if (cnt_q == lim_m1) q_d = tgt;
      else                 cnt_d = cnt_q + 1'b1;
    end
  end

  // Output and counter state; reset forces the all-low-input output level.
  always_ff @(posedge U or posedge RESET) begin
    if (RESET) begin
      q_q   <= RST_Q;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign q_o = q_q;
endmodule

module stand_cell_bank #(
  parameter int WIDTH  = 1,
  parameter int TPHL   = 7,
  parameter int TPLH   = 31,
  parameter int INVERT = 1
) (
  input  logic             U,
  input  logic             RESET,
  input  logic [WIDTH-1:0] D,
`ifdef STANDCELL_BUSY_EN
  output logic [WIDTH-1:0] BUSY,
`endif
  output logic [WIDTH-1:0] _Q
);
  localparam int TMAX = (TPHL > TPLH) ? TPHL : TPLH;
  localparam int CW   = (TMAX < 1) ? 1 : $clog2(TMAX + 1);

  if (WIDTH < 1 || TPHL < 1 || TPLH < 1 || TPHL > 255 || TPLH > 255) begin : g_bad_param
    $error("stand_cell_bank: WIDTH must be >=1 and TPHL/TPLH must be 1..255");
  end

  stand_cell_lane #(
    .TPHL  (TPHL),
    .TPLH  (TPLH),
    .INVERT(INVERT),
    .CW    (CW)
  ) u_lane [WIDTH-1:0] (
    .U    (U),
    .RESET(RESET),
    .d_i  (D),
    .q_o  (_Q)
  );

`ifdef STANDCELL_BUSY_EN
  // Pending whenever the current input's target differs from the output.
  assign BUSY = ((INVERT != 0) ? ~D : D) ^ _Q;
`endif
endmodule
